reaction_bcd_timer: RTL and testbench

- Millisecond stopwatch core of the reaction-time game. Sits directly upstream of the BCD/seven-segment display path and feeds it the digit fields ones.tenths/hundreths/thousanths, in s.mmm format.
- The game FSM starts the timer when the LEDs light and stops it on the player's key press.
- Holds a best-time register that the FSM shows in its high-score state.

---
 rtl/reaction_pkg.sv | 10 +
 rtl/bcd_digit_counter.sv | 18 +
 rtl/reaction_bcd_timer.sv | 91 +++++++++
 tb/tb_reaction_bcd_timer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state enum, 16-bit BCD time type and BCD constants/helpers for the reaction-time game
package reaction_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  typedef logic [15:0] bcd_time_t;
  localparam bcd_time_t BCD_MAX = 16'h9999;
  localparam bcd_time_t BCD_ZERO = 16'h0000;
  function automatic bcd_time_t to_bcd(int unsigned v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one 0-9 BCD digit; clk/rst_n, en (carry in), hold (block increment), zero (sync clear) in; q digit and co (en at 9, independent of hold) out
module bcd_digit_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       hold,
  input  logic       zero,
  output logic [3:0] q,
  output logic       co
);
  logic [3:0] q_q, q_d;
  always_comb q_d = zero ? 4'd0 : (en && !hold) ? (q_q == 4'd9 ? 4'd0 : q_q + 4'd1) : q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= 4'd0;
    else q_q <= q_d;
  assign q = q_q;
  assign co = en && q_q == 4'd9;
endmodule

// File: rtl/reaction_bcd_timer.sv
// reaction_bcd_timer: ms BCD stopwatch with best-time register; MAX10_CLK1_50/rst_n, start/stop/clear pulses in; ones/tenths/hundreths/thousanths, best, running/timeout/new_best/false_start out; REACTION_TIMER_ANTICHEAT_EN enables false-start rejection below MIN_MS
module reaction_bcd_timer
  import reaction_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int MIN_MS = 100
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [3:0]  ones,
  output logic [3:0]  tenths,
  output logic [3:0]  hundreths,
  output logic [3:0]  thousanths,
  output logic [15:0] best,
  output logic        running,
  output logic        timeout,
  output logic        new_best,
  output logic        false_start
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(DIV);
`ifdef REACTION_TIMER_ANTICHEAT_EN
  localparam bit AC_EN = 1'b1;
`else
  localparam bit AC_EN = 1'b0;
`endif
  localparam bcd_time_t MIN_BCD = AC_EN ? to_bcd(MIN_MS) : BCD_ZERO;
  state_t state_q, state_d;
  logic [PW-1:0] psc_q, psc_d;
  logic timeout_q, timeout_d, new_best_q, new_best_d, false_start_q, false_start_d, cmp_q, cmp_d;
  bcd_time_t best_q, best_d, value;
  logic [4:0] carry;
  logic tick, sat, go, rst_dig, better, fs_hit;
  assign tick = state_q == RUN && psc_q == PW'(DIV - 1);
  assign go = start && (state_q != RUN || stop);
  assign rst_dig = clear || go;
  assign carry[0] = tick;
  // a tick arriving at 9.999 carries out of the ones digit: that is saturation, and it freezes every digit
  assign sat = carry[4];
  for (genvar g = 0; g < 4; g++) begin : g_dig
    bcd_digit_counter u_dig (
      .clk (MAX10_CLK1_50),
      .rst_n(rst_n),
      .en  (carry[g]),
      .hold(sat),
      .zero(rst_dig),
      .q   (value[4*g +: 4]),
      .co  (carry[g+1])
    );
  end
  assign better = value < best_q;
  assign fs_hit = value < MIN_BCD;
  // cmp_q marks the first HOLD cycle after a stop, so the compare sees the frozen value
  always_comb begin
    state_d = clear ? IDLE : go ? RUN : (state_q == RUN && (stop || sat)) ? HOLD : state_q;
    psc_d = (rst_dig || tick || state_q != RUN) ? '0 : psc_q + 1'b1;
    timeout_d = rst_dig ? 1'b0 : sat ? 1'b1 : timeout_q;
    cmp_d = !rst_dig && state_q == RUN && stop && !sat;
    new_best_d = rst_dig ? 1'b0 : (cmp_q && better && !fs_hit) ? 1'b1 : new_best_q;
    false_start_d = rst_dig ? 1'b0 : (cmp_q && fs_hit) ? 1'b1 : false_start_q;
    best_d = (cmp_q && better && !fs_hit) ? value : best_q;
  end
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      psc_q <= '0;
      timeout_q <= 1'b0;
      new_best_q <= 1'b0;
      false_start_q <= 1'b0;
      cmp_q <= 1'b0;
      best_q <= BCD_MAX;
    end else begin
      state_q <= state_d;
      psc_q <= psc_d;
      timeout_q <= timeout_d;
      new_best_q <= new_best_d;
      false_start_q <= false_start_d;
      cmp_q <= cmp_d;
      best_q <= best_d;
    end
  assign {ones, tenths, hundreths, thousanths} = value;
  assign best = best_q;
  assign running = state_q == RUN;
  assign timeout = timeout_q;
  assign new_best = new_best_q;
  assign false_start = false_start_q;
endmodule

// File: tb/tb_reaction_bcd_timer.sv
// tb_reaction_bcd_timer: scoreboard bench for reaction_bcd_timer (DIV=10 main instance, DIV=2 instance for saturation)
module tb_reaction_bcd_timer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic start2 = 1'b0, stop2 = 1'b0, clear2 = 1'b0;
  logic [3:0] ones, tenths, hundreths, thousanths, ones2, tenths2, hundreths2, thousanths2;
  logic [15:0] best, best2;
  logic running, timeout, new_best, false_start, running2, timeout2, new_best2, false_start2;
`ifdef REACTION_TIMER_ANTICHEAT_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif
  reaction_bcd_timer #(.CLK_HZ(10), .TICK_HZ(1), .MIN_MS(100)) dut (
    .MAX10_CLK1_50(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .ones(ones), .tenths(tenths), .hundreths(hundreths), .thousanths(thousanths),
    .best(best), .running(running), .timeout(timeout), .new_best(new_best), .false_start(false_start)
  );
  reaction_bcd_timer #(.CLK_HZ(2), .TICK_HZ(1), .MIN_MS(1)) dut2 (
    .MAX10_CLK1_50(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .clear(clear2),
    .ones(ones2), .tenths(tenths2), .hundreths(hundreths2), .thousanths(thousanths2),
    .best(best2), .running(running2), .timeout(timeout2), .new_best(new_best2), .false_start(false_start2)
  );
  always #5 clk = ~clk;
  typedef struct {string tag; logic [35:0] val;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int best_ms = 9999;
  function automatic logic [15:0] bcd(int n);
    logic [15:0] r;
    r = {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    return r;
  endfunction
  function automatic logic [35:0] mk(logic r, logic t, logic nb, logic fs, logic [15:0] d, logic [15:0] b);
    return {r, t, nb, fs, d, b};
  endfunction
  function automatic logic [35:0] obs();
    return {running, timeout, new_best, false_start, ones, tenths, hundreths, thousanths, best};
  endfunction
  function automatic logic [35:0] obs2();
    return {running2, timeout2, new_best2, false_start2, ones2, tenths2, hundreths2, thousanths2, best2};
  endfunction
  task automatic chk(string tag, logic [35:0] got, logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (run,to,nb,fs,digits,best)", tag, got, exp);
    end
  endtask
  task automatic push(string tag, logic [35:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic pop_chk(logic [35:0] got);
    exp_t e;
    if (sb.size() == 0) chk("sb_empty", got, ~got);
    else begin
      e = sb.pop_front();
      chk(e.tag, got, e.val);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic run_stop(int n);
    logic fs, upd;
    fs = AC && n < 100;
    upd = n < best_ms && !fs;
    push($sformatf("start_clr_%0d", n), mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, bcd(best_ms)));
    push($sformatf("frozen_%0d", n), mk(1'b0, 1'b0, 1'b0, 1'b0, bcd(n), bcd(best_ms)));
    if (upd) best_ms = n;
    push($sformatf("cmp_%0d", n), mk(1'b0, 1'b0, upd, fs, bcd(n), bcd(best_ms)));
    start = 1'b1; cyc(1); start = 1'b0;
    pop_chk(obs());
    cyc(10 * n - 1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    pop_chk(obs());
    cyc(1);
    pop_chk(obs());
  endtask
  initial begin
    cyc(3);
    push("reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999));
    push("reset2", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999));
    pop_chk(obs());
    pop_chk(obs2());
    rst_n = 1'b1; cyc(1);
    push("pre_tick", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999));
    push("first_tick", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h9999));
    push("val_1234", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h9999));
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(9); pop_chk(obs());
    cyc(1); pop_chk(obs());
    cyc(12330); pop_chk(obs());
    push("clear", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999));
    clear = 1'b1; cyc(1); clear = 1'b0;
    pop_chk(obs());
    run_stop(250);
    run_stop(300);
    run_stop(250);
    push("clear_start", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, bcd(best_ms)));
    start = 1'b1; cyc(1); start = 1'b0; cyc(55);
    clear = 1'b1; start = 1'b1; cyc(1); clear = 1'b0; start = 1'b0;
    pop_chk(obs());
    push("restart", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, bcd(best_ms)));
    push("restart_tick", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, bcd(best_ms)));
    start = 1'b1; cyc(1); start = 1'b0; cyc(370);
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    pop_chk(obs());
    cyc(10); pop_chk(obs());
    push("stop_idle", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, bcd(best_ms)));
    clear = 1'b1; cyc(1); clear = 1'b0;
    stop = 1'b1; cyc(1); stop = 1'b0; cyc(2);
    pop_chk(obs());
    push("sat_seed", mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0005));
    push("sat_9999", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h9999, 16'h0005));
    push("sat_hit", mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h9999, 16'h0005));
    push("sat_hold", mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h9999, 16'h0005));
    start2 = 1'b1; cyc(1); start2 = 1'b0; cyc(9);
    stop2 = 1'b1; cyc(1); stop2 = 1'b0; cyc(1);
    pop_chk(obs2());
    start2 = 1'b1; cyc(1); start2 = 1'b0;
    cyc(19999); pop_chk(obs2());
    cyc(1); pop_chk(obs2());
    cyc(5); pop_chk(obs2());
    push("val_0777", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0777, bcd(best_ms)));
    push("async_rst", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999));
    push("post_rst", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999));
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(7770); pop_chk(obs());
    rst_n = 1'b0; #1;
    pop_chk(obs());
    best_ms = 9999;
    cyc(1); rst_n = 1'b1; cyc(3);
    pop_chk(obs());
    run_stop(50);
    run_stop(150);
    if (sb.size() != 0) chk("sb_leftover", 36'(sb.size()), 36'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
